quad_speed_meter: RTL

Quadrature encoder front end that measures motor speed for the PID speed loop. It synchronises and de-glitches the raw A/B encoder lines, decodes them 4x into signed steps, and counts those steps over a fixed sampling window. At the end of each window it publishes a saturated signed speed sample with a one-cycle valid strobe, which the PID stage uses as its feedback input.

---
 rtl/qsm_pkg.sv | 25 ++
 rtl/quad_speed_meter_filter.sv | 34 +++
 rtl/quad_speed_meter.sv | 62 ++++++
 3 files changed

// File: rtl/qsm_pkg.sv
// qsm_pkg: step encoding, quadrature decode lookup and saturating clip shared by the speed meter
package qsm_pkg;
  localparam logic signed [1:0] STEP_FWD = 2'sd1;
  localparam logic signed [1:0] STEP_REV = -2'sd1;
  localparam logic signed [1:0] STEP_NONE = 2'sd0;
  typedef struct packed {
    logic signed [1:0] step;
    logic illegal;
  } dec_t;
  // Position of {A,B} along the forward cycle 00->10->11->01
  function automatic logic [1:0] phase(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction
  function automatic dec_t decode(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] d;
    d = phase(cur_ab) - phase(prev_ab);
    return '{step: d == 2'd1 ? STEP_FWD : d == 2'd3 ? STEP_REV : STEP_NONE, illegal: d == 2'd2};
  endfunction
  function automatic int sat_clip(input int v, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/quad_speed_meter_filter.sv
// enc_input_filter: 2-flop synchroniser, FILT_LEN-cycle glitch filter and settled flag for one encoder channel
module enc_input_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic filt,
  output logic stable
);
  localparam int CW = $clog2(FILT_LEN + 1);
  logic s1, s2, hit_m, hit_q;
  logic [CW-1:0] mcnt, qcnt;
  always_comb begin
    hit_m = s2 != filt && mcnt == CW'(FILT_LEN - 1);
    hit_q = s2 == filt && qcnt == CW'(FILT_LEN - 1);
  end
  // Synchroniser flops are left out of reset so they hold the live input when reset drops
  always_ff @(posedge clk) begin
    s1 <= din;
    s2 <= s1;
    if (reset) begin
      filt <= 1'b0;
      mcnt <= '0;
      qcnt <= '0;
      stable <= 1'b0;
    end else begin
      filt <= hit_m ? s2 : filt;
      mcnt <= s2 != filt && !hit_m ? mcnt + 1'b1 : '0;
      qcnt <= s2 == filt && !hit_q ? qcnt + 1'b1 : '0;
      stable <= stable | hit_m | hit_q;
    end
  end
endmodule

// File: rtl/quad_speed_meter.sv
// quad_speed_meter: 4x quadrature decode, per-window step count and saturated signed speed sample
module quad_speed_meter
  import qsm_pkg::*;
#(
  parameter int WIN_CYCLES = 50000,
  parameter int FILT_LEN = 3,
  parameter int SPEED_W = 8,
  parameter int ACC_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enc_a,
  input  logic enc_b,
  input  logic enable,
  output logic signed [SPEED_W-1:0] speed,
  output logic speed_valid,
  output logic sat,
  output logic illegal
);
  localparam int WCW = $clog2(WIN_CYCLES);
  logic fa, fb, sa, sb, primed, last;
  logic [1:0] ab, prev_ab;
  logic [WCW-1:0] wcnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [1:0] step;
  dec_t dec;
  int sum, spd;
  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_a (.clk(clk), .reset(reset), .din(enc_a), .filt(fa), .stable(sa));
  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_b (.clk(clk), .reset(reset), .din(enc_b), .filt(fb), .stable(sb));
  always_comb begin
    ab = {fa, fb};
    dec = decode(prev_ab, ab);
    step = primed ? dec.step : STEP_NONE;
    sum = int'(acc) + int'(step);
    spd = sat_clip(sum, SPEED_W);
    last = wcnt == WCW'(WIN_CYCLES - 1);
  end
  // prev_ab tracks every cycle; steps only count once both channels have settled after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      primed <= 1'b0;
      prev_ab <= '0;
      illegal <= 1'b0;
      wcnt <= '0;
      acc <= '0;
      speed <= '0;
      sat <= 1'b0;
      speed_valid <= 1'b0;
    end else begin
      prev_ab <= ab;
      primed <= primed | (sa & sb);
      illegal <= illegal | (primed & dec.illegal);
      speed_valid <= enable & last;
      wcnt <= enable && !last ? wcnt + 1'b1 : '0;
      acc <= enable && !last ? ACC_W'(sat_clip(sum, ACC_W)) : '0;
      if (enable && last) begin
        speed <= SPEED_W'(spd);
        sat <= spd != sum;
      end
    end
  end
endmodule
